// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end.
// Owns the fetch PC, issues word-aligned requests to the instruction cache, pairs the in-order
// responses with their request addresses and buffers {pc, data} for decode. A redirect restarts
// fetch at a new PC and discards every stale in-flight and buffered instruction.
//
// Optional feature: define IFETCH_MISALIGN_CHECK_EN to add the sticky fetch_misalign output.
// A redirect to a non-word-aligned PC then raises fetch_misalign and halts request issue until
// reset or a later aligned redirect. Without the macro the low PC bits are simply forced to zero.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  // Cache request channel
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  // Cache response channel
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [31:0] resp_data,
  // Control-flow redirect
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // Decode channel
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  // Fetch PC and counters
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  // Addresses of outstanding requests, oldest at pq_rd_q
  logic [31:0]   pq_mem [DEPTH];
  logic [AW-1:0] pq_wr_q, pq_wr_d;
  logic [AW-1:0] pq_rd_q, pq_rd_d;

  // Instruction FIFO toward decode
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] fifo_wr_q, fifo_wr_d;
  logic [AW-1:0] fifo_rd_q, fifo_rd_d;

  // Per-cycle decisions
  logic          halted;
  logic [CW:0]   credit_used;
  logic          req_hs;
  logic          resp_hs;
  logic          resp_keep;
  logic          inst_pop;
  logic [31:0]   redirect_target;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic halted_q, halted_d;

  assign halted         = halted_q;
  assign fetch_misalign = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Handshakes and flow control for the current cycle.
  always_comb begin
    inst_valid  = (fifo_cnt_q != '0);
    inst_pop    = inst_valid && inst_ready;
    // A decode pop this cycle frees its slot before the new request's response can arrive,
    // which is what lets a 1-cycle cache sustain one instruction per cycle with DEPTH=2.
    credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, inst_pop};
    req_valid   = !rst && (credit_used < CREDITS) && !redirect_valid && !halted;
    req_hs      = req_valid && req_ready;
    // Responses with nothing outstanding are protocol errors and are ignored.
    resp_hs     = resp_valid && (out_cnt_q != '0);
    resp_keep   = resp_hs && !redirect_valid && (drop_cnt_q == '0);
    redirect_target = redirect_pc & 32'hFFFF_FFFC;
  end

  // Static and registered-path outputs.
  always_comb begin
    req_addr   = pc_q;
    resp_ready = 1'b1;
    inst_pc    = fifo_pc[fifo_rd_q];
    inst_data  = fifo_data[fifo_rd_q];
  end

  // Next-state for PC, counters and queue pointers; redirect overrides everything.
  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q + CW'(req_hs) - CW'(resp_hs);
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q + CW'(resp_keep) - CW'(inst_pop);
    pq_wr_d    = pq_wr_q + AW'(req_hs);
    pq_rd_d    = pq_rd_q + AW'(resp_hs);
    fifo_wr_d  = fifo_wr_q + AW'(resp_keep);
    fifo_rd_d  = fifo_rd_q + AW'(inst_pop);

    if (req_hs) begin
      pc_d = pc_q + 32'd4;
    end
    if (resp_hs && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end

    if (redirect_valid) begin
      pc_d       = redirect_target;
      // Every response still owed after this cycle belongs to the old stream.
      drop_cnt_d = out_cnt_q - CW'(resp_hs);
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
    end
  end

  // State registers and queue storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pq_mem[i]    <= '0;
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      if (req_hs) begin
        pq_mem[pq_wr_q] <= pc_q;
      end
      if (resp_keep) begin
        fifo_pc[fifo_wr_q]   <= pq_mem[pq_rd_q];
        fifo_data[fifo_wr_q] <= resp_data;
      end
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  // Sticky misalignment halt: set or cleared only by a redirect.
  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = (redirect_pc[1:0] != 2'b00);
    end
  end

  // Halt flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: a directed vector table, hand sequences for wrap and misalignment,
// and a randomized run against a queue-based cache and fetch-stream model.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  ifetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        rdv;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                              input logic ir, input logic rdv, input logic [31:0] rpc,
                              input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_pc, input logic [31:0] e_data);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.rdv = rdv; v.rpc = rpc;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_data = e_data;
    return v;
  endfunction

  localparam int NV = 21;
  vec_t vecs [NV];

  // ---------------- cache and stream model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  pend_t       pend  [$];
  inst_t       buf_q [$];
  int          epoch = 0;
  logic [31:0] exp_pc;
  logic        halted_m;
  int          p_rr, p_rv, p_ir, lat_max;
  logic        redir_pend;
  logic [31:0] redir_target;
  logic        last_hs;
  logic [31:0] last_hs_addr;
  logic        s_misalign;

  // One cycle: drive at negedge, sample and predict at negedge+1, then the edge.
  task automatic cycle_cache();
    logic  exp_rv;
    int    pops;
    pend_t p;
    @(negedge clk);
    req_ready  = ($urandom_range(0, 99) < p_rr);
    resp_valid = 1'b0;
    resp_data  = $urandom();
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc && $urandom_range(0, 99) < p_rv) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(pend[0].addr);
      end
    end
    inst_ready     = ($urandom_range(0, 99) < p_ir);
    redirect_valid = redir_pend;
    redirect_pc    = redir_target;
    redir_pend     = 1'b0;
    #1;
    pops   = (buf_q.size() > 0 && inst_ready) ? 1 : 0;
    exp_rv = !redirect_valid && !halted_m &&
             (pend.size() + buf_q.size() - pops < int'(DEPTH));
    check1("req_valid", req_valid, exp_rv);
    if (exp_rv) check("req_addr", req_addr, exp_pc);
    check1("resp_ready", resp_ready, 1'b1);
    check1("inst_valid", inst_valid, buf_q.size() > 0);
    if (buf_q.size() > 0) begin
      check("inst_pc", inst_pc, buf_q[0].pc);
      check("inst_data", inst_data, buf_q[0].data);
    end
`ifdef IFETCH_MISALIGN_CHECK_EN
    check1("fetch_misalign", fetch_misalign, halted_m);
    s_misalign = fetch_misalign;
`else
    s_misalign = 1'b0;
`endif
    last_hs      = req_valid && req_ready;
    last_hs_addr = req_addr;
    if (redirect_valid) begin
      if (resp_valid) p = pend.pop_front();
      buf_q.delete();
      epoch++;
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHECK_EN
      halted_m = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (pops != 0) void'(buf_q.pop_front());
      if (resp_valid) begin
        p = pend.pop_front();
        if (p.epoch == epoch) buf_q.push_back('{pc: p.addr, data: resp_data});
      end
      if (req_valid && req_ready) begin
        pend.push_back('{addr: req_addr, due: cyc + $urandom_range(1, lat_max), epoch: epoch});
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    repeat (2) @(posedge clk);
    pend.delete();
    buf_q.delete();
    exp_pc   = RESET_PC;
    halted_m = 1'b0;
    #1 rst = 1'b0;
  endtask

  initial begin
    logic seen;
    int   hs_cnt;

    vecs[0]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h0,   32'h0);
    vecs[1]  = mk(1'b1, 1'b1, 32'h1111_0000, 1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h0,   32'h0);
    vecs[2]  = mk(1'b1, 1'b1, 32'h1111_0004, 1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000, 32'h1111_0000);
    vecs[3]  = mk(1'b1, 1'b1, 32'h1111_0008, 1'b0, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 32'h004, 32'h1111_0004);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 32'h004, 32'h1111_0004);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004, 32'h1111_0004);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008, 32'h1111_0008);
    vecs[7]  = mk(1'b1, 1'b1, 32'h1111_000C, 1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b0, 32'h0,   32'h0);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h00C, 32'h1111_000C);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 1'b0, 32'h018, 1'b0, 32'h0,   32'h0);
    vecs[10] = mk(1'b1, 1'b1, 32'hBAD0_0010, 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,   32'h0);
    vecs[11] = mk(1'b1, 1'b1, 32'hBAD0_0014, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0);
    vecs[12] = mk(1'b1, 1'b1, 32'h2000_0100, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   32'h0);
    vecs[13] = mk(1'b0, 1'b1, 32'h2000_0104, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 32'h2000_0100);
    vecs[14] = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104, 32'h2000_0104);
    vecs[15] = mk(1'b1, 1'b1, 32'h2000_0108, 1'b1, 1'b1, 32'h200, 1'b0, 32'h10C, 1'b1, 32'h104, 32'h2000_0104);
    vecs[16] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
    vecs[17] = mk(1'b1, 1'b1, 32'h3000_0200, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0,   32'h0);
    vecs[18] = mk(1'b0, 1'b1, 32'h3000_0204, 1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200, 32'h3000_0200);
    vecs[19] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204, 32'h3000_0204);
    vecs[20] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b0, 32'h0,   32'h0);

    rst            = 1'b1;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    redir_pend     = 1'b0;
    redir_target   = 32'h0;
    halted_m       = 1'b0;
    exp_pc         = RESET_PC;
    p_rr = 100; p_rv = 100; p_ir = 100; lat_max = 1;

    // Reset values, sampled while reset is still asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check1("rst req_valid", req_valid, 1'b0);
    check("rst req_addr", req_addr, RESET_PC);
    check1("rst inst_valid", inst_valid, 1'b0);
    check("rst inst_data", inst_data, 32'h0);
    check("rst inst_pc", inst_pc, 32'h0);
    check1("rst resp_ready", resp_ready, 1'b1);

    // Directed table: first row is the first cycle out of reset.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst            = 1'b0;
      req_ready      = vecs[i].rr;
      resp_valid     = vecs[i].rv;
      resp_data      = vecs[i].rd;
      inst_ready     = vecs[i].ir;
      redirect_valid = vecs[i].rdv;
      redirect_pc    = vecs[i].rpc;
      #1;
      check1($sformatf("row%0d req_valid", i), req_valid, vecs[i].e_rv);
      check($sformatf("row%0d req_addr", i), req_addr, vecs[i].e_addr);
      check1($sformatf("row%0d inst_valid", i), inst_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        check($sformatf("row%0d inst_pc", i), inst_pc, vecs[i].e_pc);
        check($sformatf("row%0d inst_data", i), inst_data, vecs[i].e_data);
      end
    end

    // Streaming with a 1-cycle cache, then a 10-cycle decode stall and release.
    do_reset();
    repeat (12) cycle_cache();
    p_ir = 0;
    repeat (10) cycle_cache();
    p_ir = 100;
    repeat (8) cycle_cache();

    // PC wrap from the top of the address space.
    redir_pend   = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    seen         = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle_cache();
      if (last_hs && last_hs_addr == 32'hFFFF_FFFC) seen = 1'b1;
    end
    check1("wrap reached", seen, 1'b1);
    cycle_cache();
    check1("wrap next hs", last_hs, 1'b1);
    check("wrap next addr", last_hs_addr, 32'h0000_0000);
    repeat (4) cycle_cache();

`ifdef IFETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetch; an aligned redirect resumes it.
    redir_pend   = 1'b1;
    redir_target = 32'h0000_0102;
    hs_cnt       = 0;
    repeat (8) begin
      cycle_cache();
      if (last_hs) hs_cnt++;
    end
    check("misalign no requests", hs_cnt, 32'd0);
    check1("misalign flag", s_misalign, 1'b1);
    redir_pend   = 1'b1;
    redir_target = 32'h0000_0200;
    seen         = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle_cache();
      if (last_hs) seen = 1'b1;
    end
    check1("resume hs", seen, 1'b1);
    check("resume addr", last_hs_addr, 32'h0000_0200);
    check1("misalign cleared", s_misalign, 1'b0);
    repeat (4) cycle_cache();
`else
    hs_cnt = 0;
`endif

    // Randomized traffic with redirects and occasional mid-stream resets.
    for (int blk = 0; blk < 16; blk++) begin
      p_rr    = $urandom_range(30, 100);
      p_rv    = $urandom_range(30, 100);
      p_ir    = $urandom_range(10, 100);
      lat_max = $urandom_range(1, 4);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 99) < 4) begin
          redir_pend   = 1'b1;
          redir_target = $urandom();
        end
        cycle_cache();
      end
      if (blk % 5 == 4) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
